led_status_ctrl: RTL and testbench
==================================

Name: led_status_ctrl

Overview:
- Parametrised, clocked successor to the per-unit RGB status decoder.
- Tracks each of NUM_UNITS units through a fault-service sequence: fault identified, block picked, block dropped.
- Drives one red, one green and one blue (z) LED per unit from registered per-unit state, so several units can show status at once.
- Sits between the bot's event/decision logic and the board LED pins.

Parameters:
- NUM_UNITS, 3, number of tracked units (>=1).
- UNIT_W, max(1,$clog2(NUM_UNITS)), width of unit_sel.
- HOLD_CYCLES, 50_000_000, cycles green stays lit after a drop (1 s at 50 MHz); must be >=1.
- BLINK_HALF, 12_500_000, half-period of red blink; used only with LED_BLINK_EN.

Ports:
- clk_50M  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- unit_sel  in  UNIT_W  unit index qualifying the event strobes.
- i_fault  in  1  fault-identified strobe, one cycle.
- p_block  in  1  block-picked strobe, one cycle.
- b_drop  in  1  block-dropped strobe, one cycle.
- r  out  NUM_UNITS  red LED per unit.
- g  out  NUM_UNITS  green LED per unit.
- z  out  NUM_UNITS  blue LED per unit.
- err  out  1  one-cycle pulse on an illegal or ignored event.
- done_cnt  out  8  saturating count of completed services.

Behaviour:
- Reset: a cycle with rst=1 forces all of the following: every unit to IDLE, r=g=z=0, all timers 0, err=0, done_cnt=0.
- Reset applied mid-hold or mid-blink aborts the sequence with no residual output.
- Event decode:
  - More than one strobe high in one cycle: only the highest-priority one is used, in the order i_fault > p_block > b_drop.
  - The chosen strobe applies only to unit unit_sel.
  - unit_sel >= NUM_UNITS: the event is ignored and err pulses.
- Per-unit FSM:
  - IDLE: LEDs off. i_fault -> FAULT. p_block or b_drop -> stay IDLE, err pulses.
  - FAULT: r=1. p_block -> PICKED. b_drop -> err, stay. i_fault -> stay, no err.
  - PICKED: z=1. b_drop -> DROPPED, timer loaded with HOLD_CYCLES-1. p_block -> stay, no err. i_fault -> err, stay.
  - DROPPED: g=1. The timer decrements each cycle.
    - Timer==0 -> IDLE and done_cnt increments, saturating at 255.
    - i_fault -> FAULT immediately, hold aborted, done_cnt not incremented.
    - p_block or b_drop -> err, hold continues.
- Outputs are registered.
  - An event sampled at edge t shows on the LEDs after edge t (one-cycle latency).
  - g is high for exactly HOLD_CYCLES consecutive cycles when the hold is not interrupted.
- err is registered: high for the cycle after the offending event, never more than one cycle per event.
- Units are independent. An event for one unit never changes another unit's state or timer.
- Within one unit, exactly one of r, g, z is high, or none in IDLE.

Optional Feature:
- Macro: LED_BLINK_EN.
- Defined:
  - A shared free-running blink counter toggles a phase bit every BLINK_HALF cycles, starting phase=1 after reset.
  - In FAULT, r = phase.
  - All other states are unchanged.
- Undefined: no blink counter is synthesised and r is steady 1 in FAULT.

Decomposition:
- Package led_pkg holds:
  - enum unit_state_t {IDLE, FAULT, PICKED, DROPPED};
  - event code enum evt_t {EV_NONE, EV_FAULT, EV_PICK, EV_DROP};
  - the priority-encode function for the three strobes.
- Sub-module led_unit_fsm: one instance per unit via generate.
  - Holds state, hold timer and LED bits.
  - Takes a decoded evt_t plus a select bit; returns per-unit err and done pulses.
- The top level handles decode, range check, err/done reduction, done_cnt and the blink counter.

Test Plan:
- Reset then idle 10 cycles -> r=g=z=0, err=0, done_cnt=0.
- NUM_UNITS=3, HOLD_CYCLES=4; unit 1 gets i_fault, p_block, b_drop on successive cycles -> r[1], then z[1], then g[1] high for exactly 4 cycles; done_cnt=1; units 0 and 2 stay dark.
- i_fault and b_drop together for unit 0 in IDLE -> FAULT (r[0]=1), err=0.
- p_block to IDLE unit 2 -> err high one cycle, LEDs unchanged; unit_sel=3 with i_fault -> err, no LED change.
- Unit 0 in DROPPED with 2 hold cycles left, i_fault -> r[0]=1 next cycle, done_cnt unchanged; rst asserted mid-hold on unit 1 -> all outputs 0 next cycle.
- LED_BLINK_EN, BLINK_HALF=3, unit 0 in FAULT -> r[0] toggles every 3 cycles; without the macro r[0] stays 1.

Source files
------------

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the LED status controller.
//   unit_state_t : per-unit fault-service progress
//   evt_t        : decoded event code after strobe prioritisation
//   encode_evt() : collapses the three event strobes into one evt_t,
//                  i_fault > p_block > b_drop
// ---------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FAULT   = 2'd1,
    PICKED  = 2'd2,
    DROPPED = 2'd3
  } unit_state_t;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_FAULT = 2'd1,
    EV_PICK  = 2'd2,
    EV_DROP  = 2'd3
  } evt_t;

  // Only the highest-priority strobe survives when several fire together.
  function automatic evt_t encode_evt(input logic i_fault,
                                      input logic p_block,
                                      input logic b_drop);
    evt_t ev;
    ev = EV_NONE;
    if (i_fault)      ev = EV_FAULT;
    else if (p_block) ev = EV_PICK;
    else if (b_drop)  ev = EV_DROP;
    return ev;
  endfunction

endpackage

// File: rtl/led_status_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_status_ctrl_if
// Bundles the event strobes and LED/status outputs of led_status_ctrl.
//   unit_sel, i_fault, p_block, b_drop : events from the decision logic
//   r, g, z                            : per-unit red/green/blue LEDs
//   err                                : one-cycle pulse on illegal/ignored event
//   done_cnt                           : saturating count of completed services
// master = event source (decision logic / bench), slave = the controller.
// ---------------------------------------------------------------------------
interface led_status_ctrl_if #(
  parameter int NUM_UNITS = 3,
  parameter int UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
);

  logic [UNIT_W-1:0]    unit_sel;
  logic                 i_fault;
  logic                 p_block;
  logic                 b_drop;
  logic [NUM_UNITS-1:0] r;
  logic [NUM_UNITS-1:0] g;
  logic [NUM_UNITS-1:0] z;
  logic                 err;
  logic [7:0]           done_cnt;

  modport master (
    output unit_sel, i_fault, p_block, b_drop,
    input  r, g, z, err, done_cnt
  );

  modport slave (
    input  unit_sel, i_fault, p_block, b_drop,
    output r, g, z, err, done_cnt
  );

endinterface

// File: rtl/led_unit_fsm.sv
// ---------------------------------------------------------------------------
// led_unit_fsm
// Tracks one unit through fault -> picked -> dropped -> hold -> idle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   evt, sel   : decoded event and "this event targets me" qualifier
//   r, g, z    : registered LED bits for this unit
//   err_pulse  : combinational, this edge's event is illegal for the state
//   done_pulse : combinational, the hold expires at this edge
// ---------------------------------------------------------------------------
module led_unit_fsm
  import led_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  evt_t evt,
  input  logic sel,
  output logic r,
  output logic g,
  output logic z,
  output logic err_pulse,
  output logic done_pulse
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  unit_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          r_q, g_q, z_q;
  evt_t          ev;

  // Next-state logic. The timer is loaded with HOLD_CYCLES-1 on the drop and
  // the unit leaves DROPPED on the edge where it is already zero, which keeps
  // green lit for exactly HOLD_CYCLES cycles.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    err_pulse  = 1'b0;
    done_pulse = 1'b0;
    ev         = sel ? evt : EV_NONE;

    case (state_q)
      IDLE: begin
        if (ev == EV_FAULT)                        state_d = FAULT;
        else if (ev == EV_PICK || ev == EV_DROP)   err_pulse = 1'b1;
      end
      FAULT: begin
        if (ev == EV_PICK)                         state_d = PICKED;
        else if (ev == EV_DROP)                    err_pulse = 1'b1;
      end
      PICKED: begin
        if (ev == EV_DROP) begin
          state_d = DROPPED;
          timer_d = HOLD_LOAD;
        end else if (ev == EV_FAULT) begin
          err_pulse = 1'b1;
        end
      end
      DROPPED: begin
        // A new fault aborts the hold without counting a completion.
        if (ev == EV_FAULT) begin
          state_d = FAULT;
          timer_d = '0;
        end else begin
          if (ev != EV_NONE) err_pulse = 1'b1;
          if (timer_q == '0) begin
            state_d    = IDLE;
            done_pulse = 1'b1;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timer and LED bits; LEDs follow the next state so they change
  // right after the edge that sampled the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      r_q     <= 1'b0;
      g_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      r_q     <= (state_d == FAULT);
      g_q     <= (state_d == DROPPED);
      z_q     <= (state_d == PICKED);
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign z = z_q;

endmodule

// File: rtl/led_status_ctrl.sv
// ---------------------------------------------------------------------------
// led_status_ctrl
// Per-unit RGB status LED controller between the bot's event logic and the
// board LED pins. One led_unit_fsm per unit; this level decodes and range
// checks the event, merges err/done pulses and keeps done_cnt.
// Ports:
//   clk_50M : system clock
//   rst     : synchronous active-high reset
//   bus     : led_status_ctrl_if.slave (unit_sel, i_fault, p_block, b_drop,
//             r, g, z, err, done_cnt)
// Optional build macro LED_BLINK_EN: red blinks in FAULT with a half period
// of BLINK_HALF cycles driven by a shared free-running counter.
// ---------------------------------------------------------------------------
module led_status_ctrl
  import led_pkg::*;
#(
  parameter int NUM_UNITS   = 3,
  parameter int UNIT_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic              clk_50M,
  input  logic              rst,
  led_status_ctrl_if.slave  bus
);

  // One extra bit so the range check also works for power-of-two unit counts.
  localparam logic [UNIT_W:0] NUM_UNITS_L = (UNIT_W + 1)'(NUM_UNITS);

  evt_t                 evt;
  logic                 in_range;
  logic                 range_err;
  logic [NUM_UNITS-1:0] sel_vec;
  logic [NUM_UNITS-1:0] r_units, g_units, z_units;
  logic [NUM_UNITS-1:0] unit_err, unit_done;
  logic                 err_q, err_d;
  logic [7:0]           done_cnt_q, done_cnt_d;
  int unsigned          done_sum;
  int unsigned          done_total;

  // Event decode and range check; out-of-range events reach no unit.
  always_comb begin
    evt       = encode_evt(bus.i_fault, bus.p_block, bus.b_drop);
    in_range  = ({1'b0, bus.unit_sel} < NUM_UNITS_L);
    range_err = (evt != EV_NONE) && !in_range;
  end

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    assign sel_vec[i] = in_range && (bus.unit_sel == UNIT_W'(i));

    led_unit_fsm #(
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_fsm (
      .clk        (clk_50M),
      .rst        (rst),
      .evt        (evt),
      .sel        (sel_vec[i]),
      .r          (r_units[i]),
      .g          (g_units[i]),
      .z          (z_units[i]),
      .err_pulse  (unit_err[i]),
      .done_pulse (unit_done[i])
    );
  end

  // Several holds can expire on the same edge, so add them all and clamp.
  always_comb begin
    err_d    = range_err | (|unit_err);
    done_sum = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      done_sum = done_sum + 32'(unit_done[k]);
    end
    done_total = 32'(done_cnt_q) + done_sum;
    done_cnt_d = (done_total > 32'd255) ? 8'hFF : done_total[7:0];
  end

  // Registered status outputs.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      done_cnt_q <= done_cnt_d;
    end
  end

`ifdef LED_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Free-running half-period counter; phase starts lit after reset.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign bus.r = r_units & {NUM_UNITS{phase_q}};
`else
  assign bus.r = r_units;
`endif

  assign bus.g        = g_units;
  assign bus.z        = z_units;
  assign bus.err      = err_q;
  assign bus.done_cnt = done_cnt_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_status_ctrl
// Scoreboard bench: stimulus steps a behavioural model at each edge and
// queues the expected outputs; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_led_status_ctrl;

  localparam int NU   = 3;
  localparam int UW   = 2;
  localparam int HOLD = 4;
  localparam int BH   = 3;

  localparam int S_IDLE    = 0;
  localparam int S_FAULT   = 1;
  localparam int S_PICKED  = 2;
  localparam int S_DROPPED = 3;

  typedef struct packed {
    logic [NU-1:0] r;
    logic [NU-1:0] g;
    logic [NU-1:0] z;
    logic          err;
    logic [7:0]    done_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  led_status_ctrl_if #(.NUM_UNITS(NU), .UNIT_W(UW)) bus ();

  led_status_ctrl #(
    .NUM_UNITS   (NU),
    .UNIT_W      (UW),
    .HOLD_CYCLES (HOLD),
    .BLINK_HALF  (BH)
  ) dut (
    .clk_50M (clk),
    .rst     (rst),
    .bus     (bus)
  );

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: service stage per unit, remaining green cycles,
  // completed count and cycles since reset (for the blink phase).
  int stage [NU];
  int left  [NU];
  int done_m;
  int since_rst;

  // Advance the model by one clock edge with the given inputs.
  task automatic modelStep(input logic rst_v, input int sel,
                           input logic f, input logic p, input logic d,
                           output exp_t e);
    logic err_m;
    int   ev;
    int   eu;
    logic phase;
    err_m = 1'b0;
    if (rst_v) begin
      for (int u = 0; u < NU; u++) begin
        stage[u] = S_IDLE;
        left[u]  = 0;
      end
      done_m    = 0;
      since_rst = 0;
    end else begin
      since_rst++;
      ev = f ? 1 : (p ? 2 : (d ? 3 : 0));
      if (ev != 0 && sel >= NU) err_m = 1'b1;
      for (int u = 0; u < NU; u++) begin
        eu = (sel == u) ? ev : 0;
        case (stage[u])
          S_IDLE: begin
            if (eu == 1) stage[u] = S_FAULT;
            else if (eu != 0) err_m = 1'b1;
          end
          S_FAULT: begin
            if (eu == 2) stage[u] = S_PICKED;
            else if (eu == 3) err_m = 1'b1;
          end
          S_PICKED: begin
            if (eu == 3) begin
              stage[u] = S_DROPPED;
              left[u]  = HOLD;
            end else if (eu == 1) err_m = 1'b1;
          end
          default: begin
            if (eu == 1) begin
              stage[u] = S_FAULT;
              left[u]  = 0;
            end else begin
              if (eu != 0) err_m = 1'b1;
              left[u]--;
              if (left[u] == 0) begin
                stage[u] = S_IDLE;
                if (done_m < 255) done_m++;
              end
            end
          end
        endcase
      end
    end
`ifdef LED_BLINK_EN
    phase = (((since_rst / BH) % 2) == 0);
`else
    phase = 1'b1;
`endif
    e.err      = rst_v ? 1'b0 : err_m;
    e.done_cnt = 8'(done_m);
    for (int u = 0; u < NU; u++) begin
      e.r[u] = (stage[u] == S_FAULT) && phase;
      e.g[u] = (stage[u] == S_DROPPED);
      e.z[u] = (stage[u] == S_PICKED);
    end
  endtask

  // Drive one cycle of inputs, then queue what the DUT must show after the edge.
  task automatic applyStimulus(input logic rst_v, input int sel,
                               input logic f, input logic p, input logic d);
    exp_t e;
    @(negedge clk);
    rst          = rst_v;
    bus.unit_sel = UW'(sel);
    bus.i_fault  = f;
    bus.p_block  = p;
    bus.b_drop   = d;
    @(posedge clk);
    modelStep(rst_v, sel, f, p, d, e);
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (bus.r !== e.r) begin
      bad++;
      $display("[TB] FAIL r: got %b expected %b at %0t", bus.r, e.r, $time);
    end
    total++;
    if (bus.g !== e.g) begin
      bad++;
      $display("[TB] FAIL g: got %b expected %b at %0t", bus.g, e.g, $time);
    end
    total++;
    if (bus.z !== e.z) begin
      bad++;
      $display("[TB] FAIL z: got %b expected %b at %0t", bus.z, e.z, $time);
    end
    total++;
    if (bus.err !== e.err) begin
      bad++;
      $display("[TB] FAIL err: got %b expected %b at %0t", bus.err, e.err, $time);
    end
    total++;
    if (bus.done_cnt !== e.done_cnt) begin
      bad++;
      $display("[TB] FAIL done_cnt: got %0d expected %0d at %0t",
               bus.done_cnt, e.done_cnt, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, so compare one entry per falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    rst          = 1'b1;
    bus.unit_sel = '0;
    bus.i_fault  = 1'b0;
    bus.p_block  = 1'b0;
    bus.b_drop   = 1'b0;

    // Reset, then idle.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (10) applyStimulus(0, 0, 0, 0, 0);

    // Full service on unit 1.
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 1);
    repeat (6) applyStimulus(0, 0, 0, 0, 0);

    // Fault and drop together on idle unit 0: fault wins, no error.
    applyStimulus(0, 0, 1, 0, 1);
    repeat (4) applyStimulus(0, 0, 0, 0, 0);

    // Illegal pick on idle unit 2, then out-of-range unit.
    applyStimulus(0, 2, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 3, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Unit 0 into hold, fault with two green cycles left.
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Reset in the middle of unit 1's hold.
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Many parallel completions to drive done_cnt into saturation.
    for (int it = 0; it < 90; it++) begin
      for (int u = 0; u < NU; u++) applyStimulus(0, u, 1, 0, 0);
      for (int u = 0; u < NU; u++) applyStimulus(0, u, 0, 1, 0);
      for (int u = 0; u < NU; u++) applyStimulus(0, u, 0, 0, 1);
      repeat (HOLD) applyStimulus(0, 0, 0, 0, 0);
    end
    repeat (3) applyStimulus(0, 0, 0, 0, 0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0));
    end
    applyStimulus(0, 0, 0, 0, 0);

    // Let the monitor drain the scoreboard.
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
